// File: rtl/sa_pkg.sv
// Shared types and helpers for the output-stationary systolic matmul engine.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sa_state_t;

  // Exact sum clamped to the signed range of a w-bit accumulator.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One output-stationary MAC PE: registered A/B pass-through plus accumulator.
module sa_pe
  import sa_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      flush,
  input  logic                      clr,
  input  logic                      load,
  input  logic signed [BITS_C-1:0]  load_data,
  input  logic                      sat_en,
  input  logic signed [BITS_AB-1:0] a_in,
  input  logic signed [BITS_AB-1:0] b_in,
  output logic signed [BITS_AB-1:0] a_out,
  output logic signed [BITS_AB-1:0] b_out,
  output logic signed [BITS_C-1:0]  acc
);

  localparam int PW = 2 * BITS_AB;

  logic signed [PW-1:0]     prod;
  logic signed [BITS_C-1:0] acc_nxt;

  always_comb begin
    prod    = PW'(a_in) * PW'(b_in);
    acc_nxt = acc + BITS_C'(prod);
    if (sat_en)
      acc_nxt = BITS_C'(sat_add(64'(acc), 64'(prod), BITS_C));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      if (flush) begin
        a_out <= '0;
        b_out <= '0;
      end else if (en) begin
        a_out <= a_in;
        b_out <= b_in;
      end
      if (clr)       acc <= '0;
      else if (load) acc <= load_data;
      else if (en)   acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/systolic_array_stream.sv
// ROWS x COLS output-stationary matmul array with input skew, K sequencing,
// zero-fill drain, bias preload and registered readout.
module systolic_array_stream
  import sa_pkg::*;
#(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int KW      = 8,
  localparam int RAW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CAW    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [KW-1:0]                  k_len,
  input  logic                           clear_acc,
  input  logic                           sat_en,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ROWS-1:0][BITS_AB-1:0]   A_in,
  input  logic [COLS-1:0][BITS_AB-1:0]   B_in,
  output logic                           busy,
  output logic                           done,
  input  logic                           wr_en,
  input  logic [RAW-1:0]                 wr_row,
  input  logic [CAW-1:0]                 wr_col,
  input  logic [BITS_C-1:0]              wr_data,
  input  logic [RAW-1:0]                 rd_row,
  input  logic [CAW-1:0]                 rd_col,
  output logic signed [BITS_C-1:0]       rd_data
);

  localparam int DRAIN_N = ROWS + COLS - 2;
  localparam int DW      = $clog2(ROWS + COLS) + 1;

  sa_state_t     state;
  logic [KW-1:0] k_q;
  logic [KW-1:0] cnt;
  logic [DW-1:0] dcnt;
  logic          sat_q;
  logic          start_acc;
  logic          feeding;
  logic          en;
  logic          wr_ok;

  assign start_acc = (state == IDLE) && start;
  assign feeding   = (state == FEED);
  assign en        = (feeding && in_valid) || (state == DRAIN);
  assign wr_ok     = (state == IDLE) && wr_en && !start;
  assign in_ready  = feeding;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k_q   <= '0;
      cnt   <= '0;
      dcnt  <= '0;
      sat_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          k_q   <= k_len;
          sat_q <= sat_en;
          cnt   <= '0;
          dcnt  <= '0;
          state <= (k_len == '0) ? DONE : FEED;
        end
        FEED: if (in_valid) begin
          cnt <= cnt + KW'(1);
          if (cnt == k_q - KW'(1)) state <= (DRAIN_N == 0) ? DONE : DRAIN;
        end
        DRAIN: begin
          dcnt <= dcnt + DW'(1);
          if (int'(dcnt) == DRAIN_N - 1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Skew lines: lane n is delayed by n enabled cycles; zeros enter outside FEED.
  logic [BITS_AB-1:0] a_edge [ROWS];
  logic [BITS_AB-1:0] b_edge [COLS];

  for (genvar i = 0; i < ROWS; i++) begin : g_ska
    logic [BITS_AB-1:0] src;
    assign src = feeding ? A_in[i] : '0;
    if (i == 0) begin : g_direct
      assign a_edge[i] = src;
    end else begin : g_sr
      logic [BITS_AB-1:0] sr [i];
      always_ff @(posedge clk) begin
        if (rst || start_acc) begin
          for (int k = 0; k < i; k++) sr[k] <= '0;
        end else if (en) begin
          sr[0] <= src;
          for (int k = 1; k < i; k++) sr[k] <= sr[k-1];
        end
      end
      assign a_edge[i] = sr[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_skb
    logic [BITS_AB-1:0] src;
    assign src = feeding ? B_in[j] : '0;
    if (j == 0) begin : g_direct
      assign b_edge[j] = src;
    end else begin : g_sr
      logic [BITS_AB-1:0] sr [j];
      always_ff @(posedge clk) begin
        if (rst || start_acc) begin
          for (int k = 0; k < j; k++) sr[k] <= '0;
        end else if (en) begin
          sr[0] <= src;
          for (int k = 1; k < j; k++) sr[k] <= sr[k-1];
        end
      end
      assign b_edge[j] = sr[j-1];
    end
  end

  logic signed [BITS_AB-1:0] a_w   [ROWS][COLS];
  logic signed [BITS_AB-1:0] b_w   [ROWS][COLS];
  logic signed [BITS_C-1:0]  acc_w [ROWS][COLS];

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic [BITS_AB-1:0] a_left;
      logic [BITS_AB-1:0] b_up;
      if (j == 0) begin : g_al
        assign a_left = a_edge[i];
      end else begin : g_ai
        assign a_left = a_w[i][j-1];
      end
      if (i == 0) begin : g_bu
        assign b_up = b_edge[j];
      end else begin : g_bi
        assign b_up = b_w[i-1][j];
      end
      sa_pe #(.BITS_AB(BITS_AB), .BITS_C(BITS_C)) u_pe (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (start_acc),
        .clr       (start_acc && clear_acc),
        .load      (wr_ok && (int'(wr_row) == i) && (int'(wr_col) == j)),
        .load_data (wr_data),
        .sat_en    (sat_q),
        .a_in      (a_left),
        .b_in      (b_up),
        .a_out     (a_w[i][j]),
        .b_out     (b_w[i][j]),
        .acc       (acc_w[i][j])
      );
    end
    // Right-edge A outputs leave the array.
    logic unused_a;
    assign unused_a = ^a_w[i][COLS-1];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_bot
    logic unused_b;
    assign unused_b = ^b_w[ROWS-1][j];
  end

  always_ff @(posedge clk) begin
    if (rst)
      rd_data <= '0;
    else if ((int'(rd_row) < ROWS) && (int'(rd_col) < COLS))
      rd_data <= acc_w[rd_row][rd_col];
    else
      rd_data <= '0;
  end

endmodule
